l1a_event_fifo: RTL

//  Upstream of the L1A checker FSM. Counts L1As and queues a 4-byte record per L1A: B4 tag, L1A# low, L1A# high, B5 tag.
//  The checker pops bytes with READ_ENA and consumes MT/LAST/NEW_EVENT to flush or match events.

---
 rtl/l1a_fifo_pkg.sv | 28 ++
 rtl/l1a_event_fifo_if.sv | 47 ++++
 rtl/l1a_fifo_ram.sv | 42 ++++
 rtl/l1a_event_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/l1a_fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : l1a_fifo_pkg                                                      |
// | Brief  : Shared constants and write-FSM encoding for the L1A event FIFO.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package l1a_fifo_pkg;

    localparam logic [7:0] TAG_B4_DFLT = 8'hB4;
    localparam logic [7:0] TAG_B5_DFLT = 8'hB5;
    localparam int         REC_LEN     = 4;

    typedef logic [2:0] wstate_t;

    localparam logic [2:0] W_IDLE = 3'd0;
    localparam logic [2:0] W_B4   = 3'd1;
    localparam logic [2:0] W_L1L  = 3'd2;
    localparam logic [2:0] W_L1H  = 3'd3;
    localparam logic [2:0] W_B5   = 3'd4;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1a_event_fifo_if.sv
// +----------------------------------------------------------------------------+
// | Module : l1a_event_fifo_if                                                 |
// | Brief  : Checker-side bundle of the L1A event FIFO (L1A_FIFO_PARITY_EN     |
// |          adds DOUT_PERR).                                                  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface l1a_event_fifo_if #(
    parameter int ADDR_W = 6
);
    logic              L1A;
    logic              EVCNT_RST;
    logic              RD_EN;
    logic              CLR_OVFL;
    logic [7:0]        DOUT;
    logic              MT;
    logic              LAST;
    logic              NEW_EVENT;
    logic              FULL;
    logic              OVFL;
    logic [15:0]       L1A_NUM;
    logic [ADDR_W-2:0] REC_CNT;
`ifdef L1A_FIFO_PARITY_EN
    logic              DOUT_PERR;

    modport master (
        output L1A, EVCNT_RST, RD_EN, CLR_OVFL,
        input  DOUT, MT, LAST, NEW_EVENT, FULL, OVFL, L1A_NUM, REC_CNT, DOUT_PERR
    );
    modport slave (
        input  L1A, EVCNT_RST, RD_EN, CLR_OVFL,
        output DOUT, MT, LAST, NEW_EVENT, FULL, OVFL, L1A_NUM, REC_CNT, DOUT_PERR
    );
`else
    modport master (
        output L1A, EVCNT_RST, RD_EN, CLR_OVFL,
        input  DOUT, MT, LAST, NEW_EVENT, FULL, OVFL, L1A_NUM, REC_CNT
    );
    modport slave (
        input  L1A, EVCNT_RST, RD_EN, CLR_OVFL,
        output DOUT, MT, LAST, NEW_EVENT, FULL, OVFL, L1A_NUM, REC_CNT
    );
`endif
endinterface

`default_nettype wire

// File: rtl/l1a_fifo_ram.sv
// +----------------------------------------------------------------------------+
// | Module : l1a_fifo_ram                                                      |
// | Brief  : Simple dual-port RAM, sync write, registered read with enable.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module l1a_fifo_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge CLK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read register is reset so the popped-byte output starts at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/l1a_event_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : l1a_event_fifo                                                    |
// | Brief  : L1A counter plus byte FIFO of 4-byte event records (B4,lo,hi,B5). |
// |          Define L1A_FIFO_PARITY_EN for a 9-bit RAM and DOUT_PERR.          |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module l1a_event_fifo
    import l1a_fifo_pkg::*;
#(
    parameter int         ADDR_W = 6,
    parameter logic [7:0] TAG_B4 = TAG_B4_DFLT,
    parameter logic [7:0] TAG_B5 = TAG_B5_DFLT
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    l1a_event_fifo_if.slave  bus
);

    localparam int              c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_FULL_LIM = (ADDR_W+1)'(c_DEPTH - REC_LEN);
    localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);
`ifdef L1A_FIFO_PARITY_EN
    localparam int              c_DATA_W   = 9;
`else
    localparam int              c_DATA_W   = 8;
`endif

    wstate_t           r_state;
    wstate_t           w_state_nxt;
    logic [1:0]        r_pend;
    logic [15:0]       r_pend_num [0:3];
    logic [15:0]       r_evt_num;
    logic [15:0]       r_l1a_num;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W-2:0] r_rec_cnt;
    logic              r_ovfl;

    logic [ADDR_W:0]   w_used;
    logic              w_full;
    logic              w_full_b5;
    logic              w_mt;
    logic [15:0]       w_cnt_nxt;
    logic              w_idle;
    logic              w_idle_evt;
    logic              w_b5_go;
    logic              w_pop;
    logic              w_start;
    logic              w_direct;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_drop;
    logic [1:0]        w_q_idx;
    logic              w_we;
    logic              w_rd;
    logic              w_rec_inc;
    logic              w_rec_dec;
    logic [7:0]        w_byte;
    logic [c_DATA_W-1:0] w_wdata;
    logic [c_DATA_W-1:0] w_rdata;

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = w_used > c_FULL_LIM;
    // Space check as it will stand once the B5 byte is written this cycle.
    assign w_full_b5 = (w_used + c_ONE) > c_FULL_LIM;
    assign w_mt      = (r_rec_cnt == '0);

    assign w_cnt_nxt = bus.EVCNT_RST ? 16'h0000 :
                       bus.L1A       ? r_l1a_num + 16'h0001 : r_l1a_num;

    assign w_idle     = (r_state == W_IDLE);
    assign w_idle_evt = w_idle && ((r_pend != 2'd0) || bus.L1A);
    assign w_b5_go    = (r_state == W_B5) && (r_pend != 2'd0) && !w_full_b5;
    assign w_pop      = (w_idle_evt && (r_pend != 2'd0)) || w_b5_go;
    assign w_start    = (w_idle_evt && !w_full) || w_b5_go;
    assign w_direct   = w_idle && (r_pend == 2'd0) && bus.L1A;
    assign w_push_req = bus.L1A && !w_direct;
    assign w_push_ok  = w_push_req && ((r_pend != 2'd3) || w_pop);
    assign w_drop     = (w_push_req && !w_push_ok) || (w_idle_evt && w_full);
    assign w_q_idx    = r_pend - {1'b0, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE:  w_state_nxt = w_start ? W_B4 : W_IDLE;
            W_B4:    w_state_nxt = W_L1L;
            W_L1L:   w_state_nxt = W_L1H;
            W_L1H:   w_state_nxt = W_B5;
            W_B5:    w_state_nxt = w_b5_go ? W_B4 : W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= W_IDLE;
            r_pend    <= 2'd0;
            r_evt_num <= 16'h0000;
            r_l1a_num <= 16'h0000;
            r_ovfl    <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_pend_num[i] <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_l1a_num <= w_cnt_nxt;
            r_pend    <= r_pend + {1'b0, w_push_ok} - {1'b0, w_pop};
            if (w_start)
                r_evt_num <= (r_pend != 2'd0) ? r_pend_num[0] : w_cnt_nxt;
            if (w_pop) begin
                r_pend_num[0] <= r_pend_num[1];
                r_pend_num[1] <= r_pend_num[2];
                r_pend_num[2] <= r_pend_num[3];
            end
            // Queued numbers keep each pending event tied to its own L1A count.
            if (w_push_ok)
                r_pend_num[w_q_idx] <= w_cnt_nxt;
            if (w_drop)
                r_ovfl <= 1'b1;
            else if (bus.CLR_OVFL)
                r_ovfl <= 1'b0;
        end
    end

    always_comb begin
        w_byte = TAG_B5;
        case (r_state)
            W_B4:    w_byte = TAG_B4;
            W_L1L:   w_byte = r_evt_num[7:0];
            W_L1H:   w_byte = r_evt_num[15:8];
            default: w_byte = TAG_B5;
        endcase
    end

`ifdef L1A_FIFO_PARITY_EN
    assign w_wdata = {even_par(w_byte), w_byte};
`else
    assign w_wdata = w_byte;
`endif

    assign w_we      = !w_idle;
    assign w_rd      = bus.RD_EN && !w_mt;
    assign w_rec_inc = (r_state == W_B5);
    assign w_rec_dec = w_rd && (r_rd_ptr[1:0] == 2'd3);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rec_cnt <= '0;
        end else begin
            if (w_we)
                r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + c_ONE;
            if (w_rec_inc && !w_rec_dec)
                r_rec_cnt <= r_rec_cnt + 1'b1;
            else if (w_rec_dec && !w_rec_inc)
                r_rec_cnt <= r_rec_cnt - 1'b1;
        end
    end

    l1a_fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_rd),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.DOUT      = w_rdata[7:0];
    assign bus.MT        = w_mt;
    assign bus.LAST      = (r_rec_cnt == (ADDR_W-1)'(1));
    assign bus.NEW_EVENT = (r_rd_ptr[1:0] == 2'd0) && !w_mt;
    assign bus.FULL      = w_full;
    assign bus.OVFL      = r_ovfl;
    assign bus.L1A_NUM   = r_l1a_num;
    assign bus.REC_CNT   = r_rec_cnt;
`ifdef L1A_FIFO_PARITY_EN
    assign bus.DOUT_PERR = ^w_rdata;
`endif

endmodule

`default_nettype wire
